// File: rtl/clk_period_meas.sv
// Measures period and high time of a monitored clock in system-clock cycles and
// delivers each result over a valid/ready handshake, with an optional stall timeout.
module clk_period_meas #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clk_mon_i,
  input  logic [WIDTH-1:0] tmo_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             ovf_o,
  output logic             tmo_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StHold} state_e;

  state_e           state_q, state_d;
  logic             mon_s, m_q;
  logic             rise, fall, tmo_hit;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             hseen_q, hseen_d;
  logic [WIDTH-1:0] hlat_q, hlat_d;
  logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign mon_s = clk_mon_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= clk_mon_i;
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign mon_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise    = mon_s & ~m_q;
  assign fall    = ~mon_s & m_q;
  // A rise in the same cycle as the limit wins over the timeout.
  assign tmo_hit = (tmo_i != '0) && (cnt_q == tmo_i) && !rise;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      m_q      <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      hseen_q  <= 1'b0;
      hlat_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= mon_s;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      hseen_q  <= hseen_d;
      hlat_q   <= hlat_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (en_i) state_d = StArm;
      StArm, StMeas: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (rise) begin
          state_d = (state_q == StArm) ? StMeas : StHold;
        end else if (tmo_hit) begin
          state_d = StHold;
        end
      end
      StHold: if (ready_i) state_d = en_i ? StArm : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    hseen_d  = hseen_q;
    hlat_d   = hlat_q;
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    case (state_q)
      StArm, StMeas: begin
        if (!en_i) begin
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (rise && state_q == StArm) begin
          cnt_d   = One;
          sat_d   = 1'b0;
          hseen_d = 1'b0;
          hlat_d  = '0;
        end else if (rise) begin
          period_d = cnt_q;
          high_d   = hlat_q;
          ovf_d    = sat_q;
          tmo_d    = 1'b0;
        end else if (tmo_hit) begin
          period_d = '0;
          high_d   = '0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b1;
        end else begin
          if (cnt_q == '1) sat_d = 1'b1;
          else             cnt_d = cnt_q + One;
          if (state_q == StMeas && fall && !hseen_q) begin
            hlat_d  = cnt_q;
            hseen_d = 1'b1;
          end
        end
      end
      default: begin
        // Idle and the accepted-result exit both restart counting from zero.
        if (state_q == StIdle || ready_i) begin
          cnt_d = '0;
          sat_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    valid_o  = (state_q == StHold);
    busy_o   = (state_q != StIdle);
    period_o = period_q;
    high_o   = high_q;
    ovf_o    = ovf_q;
    tmo_o    = tmo_q;
  end

endmodule
